// File: rtl/wb_mem_responder_if.sv
// Wishbone B4 pipelined bus bundle between the load/store unit (master)
// and the data memory responder (slave).
interface wb_mem_responder_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic        wb_stall_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_stall_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_stall_o
    );
endinterface

// File: rtl/wb_mem_responder.sv
// Wishbone B4 pipelined responder in front of a word-addressed, byte-writable
// memory of 2**DEPTH_LOG2 32-bit words. Writes commit at the acceptance edge,
// reads latch the full word into the output register at the acceptance edge.
// Optional wait states: define ECAP5_DPROC_WB_WAIT_STATES_EN to compile in the
// IDLE/WAIT FSM that delays each ack by WAIT_CYCLES cycles and stalls the bus
// meanwhile. Without the macro the ack always follows one cycle after
// acceptance and stall is tied low.
module wb_mem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    wb_mem_responder_if.slave wb
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    if (WAIT_CYCLES < 0) begin : g_bad_wait_cycles
        $error("wb_mem_responder: WAIT_CYCLES must be non-negative");
    end

    logic [31:0]           mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] word_idx_s;
    logic                  accept_s;
    logic                  stall_s;
    logic                  ack_r;
    logic [31:0]           dat_r;
    logic                  unused_adr_s;

    // Word select; byte offset and bits above the memory size alias away.
    assign word_idx_s   = wb.wb_adr_i[DEPTH_LOG2+1:2];
    assign unused_adr_s = ^{wb.wb_adr_i[31:DEPTH_LOG2+2], wb.wb_adr_i[1:0]};

    // A request is taken only inside an active bus cycle and when not stalled.
    assign accept_s = wb.wb_cyc_i & wb.wb_stb_i & ~stall_s;

    // Byte-lane write into the array at the acceptance edge; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (accept_s && wb.wb_we_i) begin
            for (int k = 0; k < 4; k++) begin
                if (wb.wb_sel_i[k]) begin
                    mem_r[word_idx_s][8*k +: 8] <= wb.wb_dat_i[8*k +: 8];
                end
            end
        end
    end

    // Read data register: loaded only by accepted reads, held across write acks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dat_r <= 32'h0000_0000;
        end else if (accept_s && !wb.wb_we_i) begin
            dat_r <= mem_r[word_idx_s];
        end
    end

`ifdef ECAP5_DPROC_WB_WAIT_STATES_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             stall_r;
    logic             stall_nxt_s;
    logic             ack_nxt_s;

    assign stall_s = stall_r;

    // FSM, wait counter, stall and ack registers; reset drops any pending ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            stall_r <= 1'b0;
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            stall_r <= stall_nxt_s;
            ack_r   <= ack_nxt_s;
        end
    end

    // Next-state logic: count down the wait, ack on expiry, abort on cyc loss.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_nxt_s = stall_r;
        ack_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (WAIT_CYCLES > 0) begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = CNT_W'(WAIT_CYCLES - 1);
                        stall_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        stall_nxt_s = 1'b0;
                        ack_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                    stall_nxt_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (!wb.wb_cyc_i) begin
                    // Initiator dropped the cycle: forget the request, no ack.
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    stall_nxt_s = 1'b0;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_IDLE;
                    stall_nxt_s = 1'b0;
                    ack_nxt_s   = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1'b1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
                stall_nxt_s = 1'b0;
            end
        endcase
    end
`else
    assign stall_s = 1'b0;

    // Zero-wait responder: every accepted request is acked on the next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_r <= 1'b0;
        end else begin
            ack_r <= accept_s;
        end
    end
`endif

    assign wb.wb_ack_o   = ack_r;
    assign wb.wb_stall_o = stall_s;
    assign wb.wb_dat_o   = dat_r;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Scoreboard bench for wb_mem_responder. A driver issues directed and random
// Wishbone requests and pushes the expected ack (edge index + data) computed
// from a word-array model; a negedge monitor pops and compares on every ack.
module tb_wb_mem_responder;
    localparam int DEPTH_LOG2  = 10;
    localparam int WAIT_CYCLES = 2;
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
`ifdef ECAP5_DPROC_WB_WAIT_STATES_EN
    localparam int unsigned LAT = WAIT_CYCLES;
`else
    localparam int unsigned LAT = 0;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    wb_mem_responder_if bus();

    wb_mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .wb    (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned cyc;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned edge_cnt = 0;
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] model_mem [int unsigned];
    logic [31:0] last_rd = 32'h0;
    int unsigned stall_until = 0;

    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: apply one request accepted at edge e and queue its ack.
    function automatic void model_apply(input logic we, input logic [31:0] adr,
                                        input logic [31:0] dat, input logic [3:0] sel,
                                        input int unsigned e, input bit push);
        int unsigned a;
        int unsigned idx;
        logic [31:0] w;
        exp_t x;
        a   = adr;
        idx = (a % (4 * DEPTH)) / 4;
        if (we) begin
            w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (sel[k]) w[8*k +: 8] = dat[8*k +: 8];
            end
            model_mem[idx] = w;
        end else begin
            last_rd = model_mem[idx];
        end
        x.dat = last_rd;
        x.cyc = e + LAT;
        if (push) exp_q.push_back(x);
        stall_until = e + LAT;
    endfunction

    // Monitor: compare every ack against the head of the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
                check("missing_ack", edge_cnt, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (bus.wb_ack_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_cycle", edge_cnt, mon_e.cyc);
                    check("ack_data", bus.wb_dat_o, mon_e.dat);
                end
            end
        end
    end

    // Present one request (called at a negedge) and hold it until accepted.
    task automatic do_req(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
        bit done;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            check("stall", {31'b0, bus.wb_stall_o}, {31'b0, (edge_cnt < stall_until)});
            if (bus.wb_stall_o === 1'b0) begin
                model_apply(we, adr, dat, sel, edge_cnt + 1, 1'b1);
                done = 1'b1;
            end
            @(posedge clk_i);
            @(negedge clk_i);
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Stop strobing, keep the cycle open until all acks are in, then close it.
    task automatic idle();
        bus.wb_stb_i = 1'b0;
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            #1;
        end
        if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 32'd0);
        bus.wb_cyc_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 32'h0;
        bus.wb_dat_i = 32'h0;
        bus.wb_sel_i = 4'h0;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("reset_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        check("reset_stall", {31'b0, bus.wb_stall_o}, 32'd0);
        check("reset_dat", bus.wb_dat_o, 32'h0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Word write then read-after-write on the next edge.
        do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        do_req(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        idle();

        // Byte lanes and an empty select.
        do_req(1'b1, 32'h0000_0030, 32'h1122_3344, 4'hF);
        do_req(1'b1, 32'h0000_0030, 32'hAABB_CCDD, 4'b0101);
        do_req(1'b0, 32'h0000_0030, 32'h0, 4'hF);
        do_req(1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'b0000);
        do_req(1'b0, 32'h0000_0030, 32'h0, 4'hF);
        idle();

        // Back-to-back reads of four consecutive words.
        for (int i = 0; i < 4; i++) do_req(1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) do_req(1'b0, 32'(4 * i), 32'h0, 4'hF);
        idle();

        // Aliasing: upper bits and byte offset are ignored.
        do_req(1'b1, 32'h0000_1004, 32'hCAFE_0004, 4'hF);
        do_req(1'b0, 32'h0000_0004, 32'h0, 4'hF);
        do_req(1'b0, 32'hFFFF_F007, 32'h0, 4'hF);
        idle();

        // Abort: drop cyc right after a write is accepted.
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = 32'h0000_0020;
        bus.wb_dat_i = 32'h5A5A_5A5A;
        bus.wb_sel_i = 4'hF;
        check("abort_pre_stall", {31'b0, bus.wb_stall_o}, 32'd0);
        model_apply(1'b1, 32'h0000_0020, 32'h5A5A_5A5A, 4'hF, edge_cnt + 1, (LAT == 0));
        @(posedge clk_i);
        @(negedge clk_i);
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        if (stall_until > edge_cnt + 1) stall_until = edge_cnt + 1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("abort_stall", {31'b0, bus.wb_stall_o}, 32'd0);
        repeat (4) @(negedge clk_i);
        do_req(1'b0, 32'h0000_0020, 32'h0, 4'hF);
        idle();

        // Random traffic over a fully preloaded window of 64 words.
        for (int i = 0; i < 64; i++) do_req(1'b1, 32'((64 + i) * 4), $urandom, 4'hF);
        idle();
        for (int i = 0; i < 200; i++) begin
            a = ($urandom & 32'hFFFF_F003) | 32'((64 + $urandom_range(0, 63)) << 2);
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        // Reset while a read is outstanding; memory must survive.
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 32'h0000_0010;
        bus.wb_sel_i = 4'hF;
        model_apply(1'b0, 32'h0000_0010, 32'h0, 4'hF, edge_cnt + 1, 1'b1);
        @(posedge clk_i);
        #2;
        bus.wb_stb_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check("rst_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        check("rst_stall", {31'b0, bus.wb_stall_o}, 32'd0);
        check("rst_dat", bus.wb_dat_o, 32'h0);
        exp_q.delete();
        last_rd = 32'h0;
        stall_until = 0;
        bus.wb_cyc_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        do_req(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF);
        do_req(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        idle();

        repeat (3) @(negedge clk_i);
        if (exp_q.size() > 0) check("final_queue", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_mem_responder.md
# wb_mem_responder

Wishbone B4 pipelined responder backing a word-addressed, byte-writable memory. It sits on the far end of the data bus driven by the load/store unit and accepts reads and writes with optional wait states. It serves as the bench-side and FPGA-side data memory for exercising the core's memory path.

## Interface
Parameters:
- DEPTH_LOG2, default 10: memory depth in 32-bit words is 2**DEPTH_LOG2.
- WAIT_CYCLES, default 2: extra cycles inserted before each ack. Used only with the wait-state macro defined.

Ports:
- clk_i  in  1: clock; all logic is rising-edge.
- rst_i  in  1: reset, asynchronous, active-high.
- wb_adr_i  in  32: byte address. Bits [DEPTH_LOG2+1:2] select the word; other bits are ignored.
- wb_dat_i  in  32: write data.
- wb_dat_o  out  32: read data; valid only while wb_ack_o=1.
- wb_we_i  in  1: 1 = write, 0 = read.
- wb_sel_i  in  4: byte-lane enables; bit k enables byte lane [8k+7:8k].
- wb_stb_i  in  1: request strobe.
- wb_cyc_i  in  1: bus cycle active.
- wb_ack_o  out  1: one-cycle acknowledge per accepted request.
- wb_stall_o  out  1: request not accepted this cycle.

## Operation
- **Acceptance:** a request is accepted at a rising edge where wb_cyc_i & wb_stb_i & ~wb_stall_o = 1.
- **Write:** memory is updated at the acceptance edge for enabled byte lanes only. wb_sel_i=0000 is still acked and changes nothing.
- **Read:** the full word is latched into the wb_dat_o register at the acceptance edge. If a write is accepted at edge N and a read at edge N+1, the read returns the written data.
- **Write acks:** wb_dat_o keeps its previous value.
- **Address aliasing:** addresses wrap modulo 2**(DEPTH_LOG2+2). wb_adr_i[1:0] is ignored; the byte/half alignment is done by the initiator.
- **Memory contents:** not reset; contents are undefined until written.
- **Cycle abort:** if wb_cyc_i=0 while a request is pending (wait or ack pending), the responder returns to idle.
  - No ack is issued for the aborted request.
  - A write already committed at its acceptance edge stays committed.
  - wb_stb_i without wb_cyc_i is ignored.
- **Wait-state FSM** (macro defined), states IDLE and WAIT:
  - IDLE -> WAIT on acceptance when WAIT_CYCLES>0; the counter loads WAIT_CYCLES-1.
  - WAIT: counter decrements. At counter=0, the next edge sets ack and returns to IDLE.
  - WAIT_CYCLES=0: no WAIT state; behaves as without the macro.

## Timing
- **Reset values:** wb_ack_o=0, wb_stall_o=0, wb_dat_o=0, FSM=IDLE, counter=0. Reset takes effect immediately and asynchronously, including mid-transaction; pending acks are discarded.
- **Without wait states:** a request accepted at edge N gives wb_ack_o=1 during cycle N+1 (between edges N and N+1). wb_stall_o is always 0, so one request per cycle is sustained and acks follow back-to-back.
- **With wait states:** a request accepted at edge N gives wb_ack_o=1 in the cycle after edge N+WAIT_CYCLES.
  - wb_stall_o=1 from edge N through edge N+WAIT_CYCLES-1.
  - wb_stall_o=0 during the ack cycle, so a new request may be accepted at the edge that ends the ack cycle.
  - Throughput is one access per WAIT_CYCLES+1 cycles.
- **Ack count:** exactly one ack per accepted, non-aborted request, in order. wb_ack_o is never asserted for two consecutive cycles in wait mode.

## Configuration
- Macro ECAP5_DPROC_WB_WAIT_STATES_EN.
- **Defined:** the WAIT FSM and counter are compiled in, and WAIT_CYCLES sets the latency and stall behaviour described above.
- **Undefined:** the FSM and counter are absent, wb_stall_o is tied to 0, ack latency is 1 cycle, and WAIT_CYCLES is ignored.

## Test plan
- **Word write/read:** write 0xDEADBEEF to 0x0000_0010 with sel=1111, then read 0x10 -> ack one cycle after each acceptance, read data 0xDEADBEEF.
- **Byte lanes:** preload 0x11223344, write 0xAABBCCDD with sel=0101 -> read returns 0x11BB33DD.
- **Back-to-back (macro undefined):** 4 consecutive accepted reads of 0x0, 0x4, 0x8, 0xC -> stall always 0, 4 consecutive ack cycles, data in order.
- **Wait states (macro defined, WAIT_CYCLES=2):** read accepted at edge 0 -> stall=1 for 2 cycles, ack in cycle 3, stall=0 in the ack cycle, second request accepted at the ack edge.
- **Abort:** deassert wb_cyc_i during WAIT after a write of 0x5A5A5A5A to 0x20 -> no ack, FSM returns to IDLE, a subsequent read of 0x20 returns 0x5A5A5A5A.
- **Reset and aliasing:** assert rst_i mid-WAIT -> ack/stall/dat_o drop to 0 immediately. With DEPTH_LOG2=10, a write at 0x1004 is read back at 0x0004.
